// File: rtl/check_sched_pkg.sv
// check_sched_pkg
// Shared definitions for the check scheduler: FSM state encoding, parameter
// defaults and the WAIT-counter width helper.
//   ST_IDLE  : arbitrating between requesters
//   ST_ISSUE : pulsing start_o to the resource
//   ST_WAIT  : waiting for done_i or timeout
//   ST_RESP  : pulsing ack_o to the owner
package check_sched_pkg;

    localparam int NUM_REQ_DEFAULT = 4;
    localparam int TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    // Counter must be able to hold the value TIMEOUT itself (saturation point).
    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/check_sched_rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin selector. Scans the request vector starting
// at index ptr and wrapping around; the first asserted request wins.
// Ports:
//   req   [N-1:0]      request vector
//   ptr   [PTR_W-1:0]  index with highest priority this arbitration
//   grant [N-1:0]      one-hot winner, all-zero when req is all-zero
module rr_arbiter
    import check_sched_pkg::*;
#(
    parameter int N     = NUM_REQ_DEFAULT,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    logic             found;
    logic [PTR_W-1:0] idx;

    // NOTE: every variable written in a combinational block gets a default
    // first, otherwise paths that skip an assignment infer a latch.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = PTR_W'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/check_sched.sv
// check_sched
// Schedules NUM_REQ requesters onto one shared check resource. A round-robin
// winner is granted, the resource is started, and the scheduler waits for
// done_i (-> ack to the owner) or TIMEOUT cycles (-> abort/timeout pulses).
// All outputs are registered.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_i     [N-1:0]   level requests
//   grant_o   [N-1:0]   one-hot current owner, zero when idle
//   start_o             one-cycle start pulse to the resource
//   busy_i              resource check flag
//   done_i              resource completion pulse
//   ack_o     [N-1:0]   one-cycle completion pulse to the owner
//   abort_o             one-cycle pulse clearing the resource flag on timeout
//   timeout_o           one-cycle timeout indication
//   err_o               sticky protocol error, cleared only by reset
module check_sched
    import check_sched_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               start_o,
    input  logic               busy_i,
    input  logic               done_i,
    output logic [NUM_REQ-1:0] ack_o,
    output logic               abort_o,
    output logic               timeout_o,
    output logic               err_o
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = cnt_width(TIMEOUT);

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               low_q, low_d;
    logic [NUM_REQ-1:0] grant_d, ack_d;
    logic               start_d, abort_d, timeout_d, err_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [PTR_W-1:0]   arb_idx;
    logic [PTR_W-1:0]   next_ptr;

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req   (req_i),
        .ptr   (ptr_q),
        .grant (arb_grant)
    );

    // Binary index of the arbiter winner, kept so ptr can advance past it.
    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) arb_idx = PTR_W'(i);
        end
    end

    assign next_ptr = (idx_q == PTR_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        low_d     = 1'b0;
        grant_d   = grant_o;
        ack_d     = '0;
        start_d   = 1'b0;
        abort_d   = 1'b0;
        timeout_d = 1'b0;
        err_d     = err_o;

        case (state_q)
            ST_IDLE: begin
                if (|req_i) begin
                    grant_d = arb_grant;
                    idx_d   = arb_idx;
                    state_d = ST_ISSUE;
                end
                // The resource flag is still set during the cycle abort_o is
                // high; it clears on the following edge, so that is not an error.
                if (done_i || (busy_i && !abort_o)) err_d = 1'b1;
            end

            ST_ISSUE: begin
                start_d = 1'b1;
                cnt_d   = '0;
                state_d = ST_WAIT;
                if (done_i) err_d = 1'b1;
            end

            ST_WAIT: begin
                if (cnt_q != CNT_W'(TIMEOUT)) cnt_d = cnt_q + 1'b1;
                // The flag rises one cycle after start_o, so the first WAIT
                // cycle is exempt; a single low cycle is tolerated.
                if (!done_i && !busy_i && cnt_q != '0) begin
                    low_d = 1'b1;
                    if (low_q) err_d = 1'b1;
                end
                if (done_i) begin
                    ptr_d   = next_ptr;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    ptr_d     = next_ptr;
                    grant_d   = '0;
                    abort_d   = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end

            ST_RESP: begin
                ack_d   = grant_o;
                grant_d = '0;
                state_d = ST_IDLE;
                if (done_i) err_d = 1'b1;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values; reset is synchronous, hence inside the
    // clocked branch rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            low_q     <= 1'b0;
            grant_o   <= '0;
            ack_o     <= '0;
            start_o   <= 1'b0;
            abort_o   <= 1'b0;
            timeout_o <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            low_q     <= low_d;
            grant_o   <= grant_d;
            ack_o     <= ack_d;
            start_o   <= start_d;
            abort_o   <= abort_d;
            timeout_o <= timeout_d;
            err_o     <= err_d;
        end
    end

endmodule

// File: doc/check_sched.md
CHECK_SCHED -- requirements
Module: check_sched

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one check resource (2..8).
REQ-002 Parameter TIMEOUT, default 255: maximum WAIT cycles before abort (1..65535).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset; sampled on rising clk.
REQ-005 req_i  input  NUM_REQ  per-requester level request for one check operation.
REQ-006 grant_o  output  NUM_REQ  one-hot owner of the resource; all-zero when idle.
REQ-007 start_o  output  1  single-cycle pulse to the resource's check-set input.
REQ-008 busy_i  input  1  resource check flag (high from the cycle after start_o until done).
REQ-009 done_i  input  1  resource completion pulse.
REQ-010 ack_o  output  NUM_REQ  one-hot, single-cycle completion pulse to the granted requester.
REQ-011 abort_o  output  1  single-cycle pulse that forces the resource flag clear on timeout.
REQ-012 timeout_o  output  1  single-cycle pulse flagging a timed-out operation.
REQ-013 err_o  output  1  sticky error: busy_i low during WAIT, or busy_i high while IDLE.

Function
REQ-014 FSM states: IDLE, ISSUE, WAIT, RESP; all outputs registered.
REQ-015 IDLE: if any req_i bit is high, round-robin select starting at pointer ptr; load one-hot grant_o; go to ISSUE the next cycle.
REQ-016 IDLE with no request: stay in IDLE, grant_o = 0.
REQ-017 ISSUE: assert start_o for exactly one cycle; clear the WAIT counter; go to WAIT.
REQ-018 WAIT: counter increments by 1 each cycle, saturating at TIMEOUT; width = clog2(TIMEOUT+1).
REQ-019 WAIT with done_i = 1: go to RESP; done_i takes priority over timeout in the same cycle.
REQ-020 WAIT with counter == TIMEOUT-1 and done_i = 0: pulse abort_o and timeout_o in the next cycle; clear grant_o; go to IDLE.
REQ-021 RESP: pulse ack_o at the granted bit for one cycle; clear grant_o; go to IDLE.
REQ-022 Latency from request to start_o: 2 cycles in IDLE (sample cycle plus ISSUE cycle); minimum request-to-ack: 4 cycles with done_i in the first WAIT cycle.
REQ-023 ptr updates to (granted index + 1) mod NUM_REQ on leaving WAIT (done or timeout); the granted requester has lowest priority in the next arbitration.
REQ-024 done_i outside WAIT is ignored and sets err_o.
REQ-025 A requester dropping req_i while granted does not cancel the operation; the ack is still issued.
REQ-026 A granted requester holding req_i high after ack is re-arbitrated normally and is not re-granted ahead of other pending requesters.
REQ-027 grant_o, ack_o and start_o are never asserted together with abort_o.
REQ-028 busy_i low for 2 or more consecutive WAIT cycles after the first WAIT cycle, without done_i, sets err_o.

Reset
REQ-029 Reset gives state IDLE, ptr = 0, counter = 0, grant_o = 0, ack_o = 0, start_o = 0, abort_o = 0, timeout_o = 0, err_o = 0.
REQ-030 Reset asserted in ISSUE, WAIT or RESP aborts the operation silently: no ack_o and no abort_o pulse; the next cycle is IDLE.
REQ-031 err_o clears only on reset.

Structure
REQ-032 Shared package check_sched_pkg holds the state enum, the TIMEOUT and NUM_REQ defaults, and the counter-width function.
REQ-033 Round-robin selection is one sub-module, rr_arbiter (inputs: request vector and ptr; output: one-hot grant), purely combinational, and is instantiated once.
REQ-034 The resource check flag module is not instantiated inside check_sched; the two are connected at the parent level.

Verification
REQ-035 Single request: req_i=0001, done_i 3 cycles after start_o -> start_o one pulse, ack_o=0001 one pulse, grant_o=0 afterward, ptr=1.
REQ-036 Fairness: req_i=1111 held for 8 operations -> grant order 0,1,2,3,0,1,2,3.
REQ-037 Timeout: TIMEOUT=4, done_i never asserted -> abort_o and timeout_o pulse 4 cycles after start_o, no ack_o, return to IDLE.
REQ-038 Simultaneous events: done_i asserted on the cycle counter==TIMEOUT-1 -> ack_o issued, no timeout_o.
REQ-039 Reset mid-WAIT: rst at WAIT cycle 2 -> all outputs 0 next cycle; a new req_i=0100 is then granted with ptr=0 ordering.
REQ-040 Protocol error: done_i pulsed while IDLE -> err_o=1 and held until rst.
